// File: rtl/mem_stage.sv
// Purpose : MEM pipeline stage; resolves branch/jump, runs the data-memory req/ack access, holds the MEM/WB register.
// Latency : pcsrc/pc_target/dmem_* combinational; MEM/WB fields one edge after the completing (ack) cycle.
// Backpress: stall=dmem_req&~dmem_ack freezes upstream; MEM/WB receives a bubble (RegWrite_wb=0) while stalled.
//
// Ports: clk/rst (sync, active-high); EX/MEM controls and data (branch, jump, MemRead, MemWrite,
//        RegWrite, MemtoReg, add_out, alu_out, aluzero, readdata2, muxRegDst); branch resolution
//        (pcsrc, pc_target); stall; data-memory port (dmem_req, dmem_we, dmem_addr, dmem_wdata,
//        dmem_rdata, dmem_ack); MEM/WB register (RegWrite_wb, MemtoReg_wb, memdata_wb, alu_wb,
//        regdst_wb); misalign_err.
// Optional: define MEM_ALIGN_CHECK_EN to reject word-misaligned accesses (no request issued,
//           bubble into MEM/WB, one-cycle misalign_err pulse). Undefined: no check, misalign_err=0.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic              jump,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] add_out,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              aluzero,
    input  logic [DATA_W-1:0] readdata2,
    input  logic [REG_W-1:0]  muxRegDst,
    output logic              pcsrc,
    output logic [DATA_W-1:0] pc_target,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [DATA_W-1:0] memdata_wb,
    output logic [DATA_W-1:0] alu_wb,
    output logic [REG_W-1:0]  regdst_wb,
    output logic              misalign_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state;
    logic       access;
    logic       misaligned;
    logic       load_done;

    assign access = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & (alu_out[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Branch resolution is never held back by a memory stall.
    assign pcsrc     = (branch & aluzero) | jump;
    assign pc_target = add_out;

    // In WAIT the request stays up regardless of access, since upstream holds the same inputs.
    assign dmem_req   = ((state == S_IDLE) & access | (state == S_WAIT)) & ~misaligned;
    assign dmem_we    = MemWrite;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = readdata2;
    assign stall      = dmem_req & ~dmem_ack;

    // Read+write together behaves as a store, so only a pure load captures read data.
    assign load_done = dmem_req & dmem_ack & MemRead & ~MemWrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            RegWrite_wb <= 1'b0;
            MemtoReg_wb <= 1'b0;
            memdata_wb  <= '0;
            alu_wb      <= '0;
            regdst_wb   <= '0;
        end else begin
            // Outstanding access (request without ack) is exactly the WAIT condition.
            state <= stall ? S_WAIT : S_IDLE;
            if (stall) begin
                RegWrite_wb <= 1'b0;
            end else begin
                RegWrite_wb <= RegWrite & ~misaligned;
                MemtoReg_wb <= MemtoReg;
                alu_wb      <= alu_out;
                regdst_wb   <= muxRegDst;
                if (load_done) begin
                    memdata_wb <= dmem_rdata;
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= misaligned;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : self-checking bench for mem_stage; transaction-level model plus directed literal checks.
// Latency : model MEM/WB updates at each rising edge; outputs compared on falling edges.
// Backpress: model treats an un-acked request as outstanding until ack, with bubbles into MEM/WB.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, jump, MemRead, MemWrite, RegWrite, MemtoReg, aluzero;
    logic [31:0] add_out, alu_out, readdata2, dmem_rdata;
    logic [4:0]  muxRegDst;
    logic        dmem_ack;
    logic        pcsrc, stall, dmem_req, dmem_we;
    logic [31:0] pc_target, dmem_addr, dmem_wdata;
    logic        RegWrite_wb, MemtoReg_wb, misalign_err;
    logic [31:0] memdata_wb, alu_wb;
    logic [4:0]  regdst_wb;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .branch(branch), .jump(jump), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .add_out(add_out),
        .alu_out(alu_out), .aluzero(aluzero), .readdata2(readdata2), .muxRegDst(muxRegDst),
        .pcsrc(pcsrc), .pc_target(pc_target), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .RegWrite_wb(RegWrite_wb),
        .MemtoReg_wb(MemtoReg_wb), .memdata_wb(memdata_wb), .alu_wb(alu_wb),
        .regdst_wb(regdst_wb), .misalign_err(misalign_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_outstanding;   // a request was issued and not yet acknowledged
    bit          m_rw, m_mtr, m_err;
    logic [31:0] m_mem, m_alu;
    logic [4:0]  m_dst;

    function automatic bit mis_now();
`ifdef MEM_ALIGN_CHECK_EN
        return (MemRead || MemWrite) && (alu_out % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit req_now();
        return ((MemRead || MemWrite) || m_outstanding) && !mis_now();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_outstanding = 0; m_rw = 0; m_mtr = 0; m_err = 0;
            m_mem = 0; m_alu = 0; m_dst = 0;
        end else begin
            bit req, mis;
            req = req_now();
            mis = mis_now();
            if (req && !dmem_ack) begin
                m_outstanding = 1;
                m_rw = 0;
            end else begin
                m_outstanding = 0;
                m_rw  = RegWrite && !mis;
                m_mtr = MemtoReg;
                m_alu = alu_out;
                m_dst = muxRegDst;
                if (req && dmem_ack && MemRead && !MemWrite) m_mem = dmem_rdata;
            end
            m_err = mis;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit req;
            req = req_now();
            chk("pcsrc", {31'b0, pcsrc}, {31'b0, (branch && aluzero) || jump});
            chk("pc_target", pc_target, add_out);
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, req});
            chk("stall", {31'b0, stall}, {31'b0, req && !dmem_ack});
            chk("dmem_we", {31'b0, dmem_we}, {31'b0, MemWrite});
            chk("dmem_addr", dmem_addr, alu_out);
            chk("dmem_wdata", dmem_wdata, readdata2);
            chk("RegWrite_wb", {31'b0, RegWrite_wb}, {31'b0, m_rw});
            chk("MemtoReg_wb", {31'b0, MemtoReg_wb}, {31'b0, m_mtr});
            chk("memdata_wb", memdata_wb, m_mem);
            chk("alu_wb", alu_wb, m_alu);
            chk("regdst_wb", {27'b0, regdst_wb}, {27'b0, m_dst});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        branch = 0; jump = 0; MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
        aluzero = 0; add_out = 0; alu_out = 0; readdata2 = 0; muxRegDst = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    initial begin
        int stall_cnt;
        rst = 1;
        bubble();
        tick();
        tick();
        rst = 0;
        chk_en = 1;
        #1;
        chk("reset RegWrite_wb", {31'b0, RegWrite_wb}, 32'd0);
        chk("reset memdata_wb", memdata_wb, 32'd0);
        chk("reset alu_wb", alu_wb, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);

        // Zero-wait load
        MemRead = 1; RegWrite = 1; MemtoReg = 1; alu_out = 32'h10; muxRegDst = 5'd5;
        dmem_ack = 1; dmem_rdata = 32'hCAFEBABE;
        #1;
        chk("zw stall", {31'b0, stall}, 32'd0);
        chk("zw req", {31'b0, dmem_req}, 32'd1);
        tick();
        bubble();
        chk("zw memdata", memdata_wb, 32'hCAFEBABE);
        chk("zw RegWrite_wb", {31'b0, RegWrite_wb}, 32'd1);
        chk("zw regdst", {27'b0, regdst_wb}, 32'd5);
        chk("zw alu_wb", alu_wb, 32'h10);

        // 3-cycle load: ack on third request cycle
        MemRead = 1; RegWrite = 1; MemtoReg = 1; alu_out = 32'h14; muxRegDst = 5'd7;
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                dmem_ack = 1; dmem_rdata = 32'h12345678;
            end
            #1;
            if (stall) stall_cnt++;
            if (i == 1) begin
                chk("3c RegWrite_wb in stall", {31'b0, RegWrite_wb}, 32'd0);
                chk("3c memdata held", memdata_wb, 32'hCAFEBABE);
            end
            tick();
        end
        bubble();
        chk("3c stall cycles", stall_cnt, 32'd2);
        chk("3c memdata", memdata_wb, 32'h12345678);
        chk("3c regdst", {27'b0, regdst_wb}, 32'd7);

        // Store with one wait cycle
        MemWrite = 1; alu_out = 32'h20; readdata2 = 32'hDEADBEEF; dmem_rdata = 32'h0BADF00D;
        #1;
        chk("st we", {31'b0, dmem_we}, 32'd1);
        chk("st stall c1", {31'b0, stall}, 32'd1);
        tick();
        dmem_ack = 1;
        #1;
        chk("st addr c2", dmem_addr, 32'h20);
        chk("st wdata c2", dmem_wdata, 32'hDEADBEEF);
        chk("st stall c2", {31'b0, stall}, 32'd0);
        tick();
        bubble();
        chk("st memdata unchanged", memdata_wb, 32'h12345678);

        // Read and write together acts as store
        MemRead = 1; MemWrite = 1; alu_out = 32'h24; dmem_ack = 1; dmem_rdata = 32'h55;
        #1;
        chk("rw we", {31'b0, dmem_we}, 32'd1);
        tick();
        bubble();
        chk("rw memdata unchanged", memdata_wb, 32'h12345678);

        // Branch / jump
        branch = 1; aluzero = 1; add_out = 32'h400;
        #1;
        chk("br taken", {31'b0, pcsrc}, 32'd1);
        chk("br target", pc_target, 32'h400);
        aluzero = 0;
        #1;
        chk("br not taken", {31'b0, pcsrc}, 32'd0);
        jump = 1;
        #1;
        chk("jump", {31'b0, pcsrc}, 32'd1);
        tick();
        bubble();

        // Reset in WAIT, then a late ack with no request
        MemRead = 1; RegWrite = 1; alu_out = 32'h30; muxRegDst = 5'd9;
        tick();
        chk("rw wait stall", {31'b0, stall}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        bubble();
        dmem_ack = 1; dmem_rdata = 32'hFFFF0000;
        #1;
        chk("late ack req", {31'b0, dmem_req}, 32'd0);
        chk("late ack stall", {31'b0, stall}, 32'd0);
        chk("post-rst alu_wb", alu_wb, 32'd0);
        chk("post-rst memdata", memdata_wb, 32'd0);
        tick();
        chk("late ack memdata", memdata_wb, 32'd0);
        dmem_ack = 0;

        // Reset in WAIT with inputs still requesting re-issues the access
        MemRead = 1; RegWrite = 1; alu_out = 32'h34;
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("reissue req", {31'b0, dmem_req}, 32'd1);
        chk("reissue stall", {31'b0, stall}, 32'd1);
        dmem_ack = 1; dmem_rdata = 32'hA5A5A5A5;
        tick();
        bubble();
        chk("reissue memdata", memdata_wb, 32'hA5A5A5A5);

        // Misaligned address
        MemRead = 1; RegWrite = 1; alu_out = 32'h13; dmem_ack = 1; dmem_rdata = 32'h77;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis req", {31'b0, dmem_req}, 32'd0);
        chk("mis stall", {31'b0, stall}, 32'd0);
        tick();
        bubble();
        chk("mis err pulse", {31'b0, misalign_err}, 32'd1);
        chk("mis RegWrite_wb", {31'b0, RegWrite_wb}, 32'd0);
        tick();
        chk("mis err one cycle", {31'b0, misalign_err}, 32'd0);
`else
        chk("unaligned req", {31'b0, dmem_req}, 32'd1);
        tick();
        bubble();
        chk("no misalign_err", {31'b0, misalign_err}, 32'd0);
        chk("unaligned memdata", memdata_wb, 32'h77);
`endif

        // A short run of mixed accesses with varying ack delays, checked by the model
        for (int k = 0; k < 12; k++) begin
            MemRead = (k % 3 != 1); MemWrite = (k % 3 == 1); RegWrite = (k % 2 == 0);
            MemtoReg = MemRead; alu_out = 32'h100 + 32'(k * 4); readdata2 = 32'(k * 32'h1111);
            muxRegDst = 5'(k + 1); branch = (k % 4 == 0); aluzero = (k % 5 == 0);
            jump = (k == 7); add_out = 32'h800 + 32'(k);
            for (int w = 0; w <= (k % 3); w++) begin
                dmem_ack = (w == (k % 3));
                dmem_rdata = 32'hC000_0000 + 32'(k);
                tick();
            end
            bubble();
            tick();
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEMORY pipeline stage: the consumer end of the EX/MEM interface produced by the execute stage.
- Resolves branch/jump, performs data-memory load/store over a req/ack handshake, and holds the MEM/WB pipeline register feeding write-back.
- Drives a stall to upstream stages while a memory access is outstanding.

Parameters:
- DATA_W, 32, data/address width
- REG_W, 5, destination register index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- branch  in  1  EX/MEM branch control
- jump  in  1  EX/MEM jump control
- MemRead  in  1  load request
- MemWrite  in  1  store request
- RegWrite  in  1  register write enable
- MemtoReg  in  1  write-back select (1 = memory data)
- add_out  in  DATA_W  branch/jump target
- alu_out  in  DATA_W  ALU result / memory address
- aluzero  in  1  ALU zero flag
- readdata2  in  DATA_W  store data
- muxRegDst  in  REG_W  destination register
- pcsrc  out  1  take target: (branch & aluzero) | jump, combinational
- pc_target  out  DATA_W  equals add_out
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- dmem_req, dmem_we  out  1 each  access request / write enable
- dmem_addr, dmem_wdata  out  DATA_W each  access address / store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- RegWrite_wb, MemtoReg_wb  out  1 each  MEM/WB registered controls
- memdata_wb, alu_wb  out  DATA_W each  MEM/WB registered load data / ALU result
- regdst_wb  out  REG_W  MEM/WB destination register
- misalign_err  out  1  registered one-cycle pulse (optional feature)

Behaviour:
- access = MemRead | MemWrite. A bubble has all controls 0.
- FSM has two states, IDLE and WAIT; reset state is IDLE.
- dmem_req = (IDLE & access) | WAIT.
- dmem_we = MemWrite.
- dmem_addr = alu_out; dmem_wdata = readdata2. All of these are combinational from the live inputs.
- Upstream holds its inputs stable while stall=1.
- stall = dmem_req & ~dmem_ack. A zero-wait memory (ack in the request cycle) causes no stall.
- IDLE -> WAIT when dmem_req & ~dmem_ack.
- WAIT -> IDLE on dmem_ack; WAIT holds otherwise, with no timeout.
- dmem_ack while dmem_req=0 is ignored.
- MEM/WB update, each rising edge:
  - stall=0: load RegWrite, MemtoReg, alu_out, muxRegDst; memdata_wb <= dmem_rdata if MemRead & dmem_ack, else unchanged.
  - stall=1: RegWrite_wb <= 0 (bubble); other MEM/WB fields hold.
- Latency: load data appears on memdata_wb one cycle after the ack cycle.
- pcsrc and pc_target are purely combinational and are not gated by stall.
- MemRead and MemWrite both 1: treated as a store (dmem_we=1); memdata_wb is not updated.
- Reset (rst=1 at edge):
  - State -> IDLE.
  - All MEM/WB outputs -> 0; misalign_err -> 0.
  - Reset mid-WAIT abandons the access. Any ack arriving after reset without a request is ignored.
  - The next cycle re-issues the request if inputs still request access.
- Outputs after reset: RegWrite_wb, MemtoReg_wb, memdata_wb, alu_wb, regdst_wb, misalign_err = 0. stall, dmem_req, pcsrc follow their equations.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN
- Defined:
  - misaligned = access & (alu_out[1:0] != 0).
  - When misaligned, dmem_req is forced to 0 and there is no stall.
  - MEM/WB loads a bubble (RegWrite_wb=0).
  - misalign_err pulses 1 for one cycle, on the next edge.
- Undefined: address passes unchanged, misalign_err is tied to 0, no check.

Test Plan:
- Zero-wait load: MemRead=1, alu_out=0x10, ack same cycle, rdata=0xCAFEBABE -> stall never 1; next edge memdata_wb=0xCAFEBABE, RegWrite_wb=1, regdst_wb as input.
- 3-cycle load: ack on 3rd req cycle -> stall=1 for 2 cycles; RegWrite_wb=0 during stall; rdata 0x12345678 on memdata_wb the edge after ack.
- Store: MemWrite=1, alu_out=0x20, readdata2=0xDEADBEEF, ack after 1 wait cycle -> dmem_we=1, addr/wdata stable over both cycles, stall=1 for one cycle.
- Branch/jump: branch=1, aluzero=1, add_out=0x400 -> pcsrc=1, pc_target=0x400; aluzero=0 -> pcsrc=0; jump=1 -> pcsrc=1.
- Reset in WAIT: rst=1 while in WAIT -> next cycle IDLE, all MEM/WB=0; a late ack with no request has no effect.
- With MEM_ALIGN_CHECK_EN: MemRead=1, alu_out=0x13 -> dmem_req=0, stall=0, misalign_err=1 for exactly one cycle, RegWrite_wb=0.
